// File: rtl/piano_pkg.sv
// Shared types, scan-code constants and tone table for the piano key path.
package piano_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } dec_state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam int unsigned NUM_KEYS = 8;
  localparam longint unsigned REF_CLK_HZ = 64'd50_000_000;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_map_t;

  function automatic key_map_t scan_to_idx(input logic [7:0] code);
    key_map_t m;
    m = '{hit: 1'b1, idx: 3'd0};
    case (code)
      8'h1C:   m.idx = 3'd0;
      8'h1B:   m.idx = 3'd1;
      8'h23:   m.idx = 3'd2;
      8'h2B:   m.idx = 3'd3;
      8'h34:   m.idx = 3'd4;
      8'h33:   m.idx = 3'd5;
      8'h3B:   m.idx = 3'd6;
      8'h42:   m.idx = 3'd7;
      default: m.hit = 1'b0;
    endcase
    return m;
  endfunction

  // C4..C5 half periods in cycles of a 50 MHz clock, truncated.
  function automatic longint unsigned half_base(input logic [2:0] idx);
    case (idx)
      3'd0:    return 64'd95556;
      3'd1:    return 64'd85131;
      3'd2:    return 64'd75843;
      3'd3:    return 64'd71586;
      3'd4:    return 64'd63775;
      3'd5:    return 64'd56818;
      3'd6:    return 64'd50619;
      default: return 64'd47778;
    endcase
  endfunction

  // Rescales the 50 MHz table to the actual clock; identity at 50 MHz.
  function automatic longint unsigned half_cycles(input longint unsigned clk_hz,
                                                  input logic [2:0] idx);
    return (half_base(idx) * clk_hz) / REF_CLK_HZ;
  endfunction

endpackage

// File: rtl/key_scheduler_tone_gen.sv
// Square-wave generator: toggles tone_out every half_period cycles while enabled.
module tone_gen #(
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic [CNT_W-1:0] half_period,
  output logic             tone_out
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart || !en) begin
      cnt      <= '0;
      tone_out <= 1'b0;
    end else if (cnt == half_period - 1'b1) begin
      cnt      <= '0;
      tone_out <= ~tone_out;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_scheduler.sv
// PS/2 make/break decoder, key bitmap and last-pressed-wins tone arbitration.
module key_scheduler
  import piano_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned CNT_W  = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_valid,
  input  logic [10:0] sda_to_do,
  input  logic [7:0]  switch_uri,
  output logic [7:0]  key_state,
  output logic        note_valid,
  output logic [2:0]  note_idx,
  output logic        tone_out,
  output logic        frame_err
);

  dec_state_t       state;
  logic             dv_q;
  logic             ev;
  logic             frame_ok;
  logic [7:0]       code;
  key_map_t         km;
  logic [2:0]       last;
  logic [7:0]       elig;
  logic             nxt_valid;
  logic [2:0]       nxt_idx;
  logic             restart;
  logic [CNT_W-1:0] half_period;

  assign ev       = data_valid & ~dv_q;
  assign frame_ok = ~sda_to_do[0] & sda_to_do[10] & (^sda_to_do[9:1]);
  assign code     = sda_to_do[8:1];
  assign km       = scan_to_idx(code);

  // Held last key wins; otherwise fall back to the lowest eligible key.
  always_comb begin
    elig      = key_state & switch_uri;
    nxt_valid = |elig;
    nxt_idx   = '0;
    if (elig[last]) begin
      nxt_idx = last;
    end else begin
      for (int unsigned i = NUM_KEYS; i > 0; i--) begin
        if (elig[i-1]) nxt_idx = 3'(i - 1);
      end
    end
    restart = (nxt_valid != note_valid) || (nxt_idx != note_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dv_q       <= 1'b0;
      key_state  <= '0;
      last       <= '0;
      frame_err  <= 1'b0;
      note_valid <= 1'b0;
      note_idx   <= '0;
    end else begin
      dv_q       <= data_valid;
      frame_err  <= ev & ~frame_ok;
      note_valid <= nxt_valid;
      note_idx   <= nxt_idx;
      if (ev) begin
        if (!frame_ok) begin
          state <= IDLE;
        end else begin
          case (state)
            IDLE: begin
              if (code == SC_BREAK) begin
                state <= BRK;
              end else if (code == SC_EXT) begin
                state <= EXT;
              end else if (km.hit && !key_state[km.idx]) begin
                key_state[km.idx] <= 1'b1;
                last              <= km.idx;
              end
            end
            BRK: begin
              state <= IDLE;
              if (km.hit) key_state[km.idx] <= 1'b0;
            end
            EXT:     state <= (code == SC_BREAK) ? EXT_BRK : IDLE;
            EXT_BRK: state <= IDLE;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  always_comb begin
    half_period = CNT_W'(half_cycles(64'(CLK_HZ), note_idx));
  end

  tone_gen #(
    .CNT_W(CNT_W)
  ) u_tone_gen (
    .clk        (clk),
    .rst        (rst),
    .en         (note_valid),
    .restart    (restart),
    .half_period(half_period),
    .tone_out   (tone_out)
  );

endmodule

// File: tb/tb_key_scheduler.sv
// Scoreboard bench for key_scheduler; clock scaled to 500 kHz so tone periods fit the run.
module tb_key_scheduler;

  localparam int K_KEY  = 0;
  localparam int K_NOTE = 1;
  localparam int K_FERR = 2;
  localparam int K_TONE = 3;
  // Half periods at 500 kHz: table entries / 100, truncated.
  localparam int H0 = 955;
  localparam int H2 = 758;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        data_valid = 1'b0;
  logic [10:0] sda_to_do = '0;
  logic [7:0]  switch_uri = 8'hFF;
  logic [7:0]  key_state;
  logic        note_valid;
  logic [2:0]  note_idx;
  logic        tone_out;
  logic        frame_err;

  exp_t  exp_q[$];
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  bit    mon_en = 1'b0;
  logic [7:0] p_key = '0;
  logic [3:0] p_note = '0;
  logic       p_tone = 1'b0;
  string kname[4] = '{"key_state", "note", "frame_err", "tone_out"};

  key_scheduler #(
    .CLK_HZ(500_000),
    .CNT_W (17)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_valid(data_valid),
    .sda_to_do (sda_to_do),
    .switch_uri(switch_uri),
    .key_state (key_state),
    .note_valid(note_valid),
    .note_idx  (note_idx),
    .tone_out  (tone_out),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check(input int kind, input int val);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected %s: got %0h at cycle %0d, none expected", kname[kind], val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: got %s=%0h at cycle %0d, required %s=%0h at cycle %0d",
                 kname[e.kind], kname[kind], val, cyc, kname[e.kind], e.val, e.cyc);
      end
    end
  endtask

  task automatic direct(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Monitor: every observable output change is matched against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      if (key_state != p_key) check(K_KEY, int'(key_state));
      if ({note_valid, note_idx} != p_note) check(K_NOTE, int'({note_valid, note_idx}));
      if (frame_err) check(K_FERR, 1);
      if (tone_out != p_tone) check(K_TONE, int'(tone_out));
    end
    p_key  = key_state;
    p_note = {note_valid, note_idx};
    p_tone = tone_out;
  end

  function automatic logic [10:0] frame_of(input logic [7:0] code);
    return {1'b1, ~^code, code, 1'b0};
  endfunction

  task automatic send(input logic [10:0] f, output int e);
    @(posedge clk); #1;
    data_valid = 1'b1;
    sda_to_do  = f;
    e = cyc + 1;
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic tick_until(input int c);
    while (cyc < c) @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    int s;
    logic [10:0] f;

    repeat (3) @(posedge clk);
    #1;
    direct("reset key_state", int'(key_state), 0);
    direct("reset note_valid", int'(note_valid), 0);
    direct("reset note_idx", int'(note_idx), 0);
    direct("reset tone_out", int'(tone_out), 0);
    direct("reset frame_err", int'(frame_err), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: press 1C, observe a full tone period
    send(frame_of(8'h1C), e);
    push(K_KEY, 8'h01, e);
    push(K_NOTE, 4'h8, e + 1);
    push(K_TONE, 1, e + 1 + H0);
    push(K_TONE, 0, e + 1 + 2 * H0);
    tick_until(e + 1 + 2 * H0 + 10);

    // 2: stack 23 and 2B on top of held 1C, then release
    send(frame_of(8'h23), e);
    push(K_KEY, 8'h05, e);
    push(K_NOTE, 4'hA, e + 1);
    tick_until(e + 20);
    send(frame_of(8'h2B), e);
    push(K_KEY, 8'h0D, e);
    push(K_NOTE, 4'hB, e + 1);
    tick_until(e + 20);
    send(frame_of(8'hF0), e);
    send(frame_of(8'h2B), e);
    push(K_KEY, 8'h05, e);
    push(K_NOTE, 4'h8, e + 1);
    tick_until(e + 10);
    send(frame_of(8'hF0), e);
    send(frame_of(8'h23), e);
    push(K_KEY, 8'h01, e);
    tick_until(e + 10);
    send(frame_of(8'hF0), e);
    send(frame_of(8'h1C), e);
    push(K_KEY, 8'h00, e);
    push(K_NOTE, 4'h0, e + 1);
    tick_until(e + 10);

    // 2b: a short-period note toggles at its own rate
    send(frame_of(8'h23), e);
    push(K_KEY, 8'h04, e);
    push(K_NOTE, 4'hA, e + 1);
    push(K_TONE, 1, e + 1 + H2);
    tick_until(e + 1 + H2 + 5);
    send(frame_of(8'hF0), e);
    send(frame_of(8'h23), e);
    push(K_KEY, 8'h00, e);
    push(K_NOTE, 4'h0, e + 1);
    push(K_TONE, 0, e + 1);
    tick_until(e + 10);

    // 3: bad parity after F0 clears the prefix; bad start/stop also rejected
    send(frame_of(8'hF0), e);
    f = frame_of(8'h1C);
    f[9] = ~f[9];
    send(f, e);
    push(K_FERR, 1, e);
    send(frame_of(8'h1C), e);
    push(K_KEY, 8'h01, e);
    push(K_NOTE, 4'h8, e + 1);
    tick_until(e + 5);
    send(frame_of(8'hF0), e);
    send(frame_of(8'h1C), e);
    push(K_KEY, 8'h00, e);
    push(K_NOTE, 4'h0, e + 1);
    f = frame_of(8'h1C);
    f[0] = 1'b1;
    send(f, e);
    push(K_FERR, 1, e);
    f = frame_of(8'h1C);
    f[10] = 1'b0;
    send(f, e);
    push(K_FERR, 1, e);
    tick_until(e + 5);

    // 4: extended make and break are ignored
    send(frame_of(8'hE0), e);
    send(frame_of(8'h1C), e);
    send(frame_of(8'hE0), e);
    send(frame_of(8'hF0), e);
    send(frame_of(8'h1C), e);
    send(frame_of(8'h1B), e);
    push(K_KEY, 8'h02, e);
    push(K_NOTE, 4'h9, e + 1);
    tick_until(e + 5);
    send(frame_of(8'hF0), e);
    send(frame_of(8'h1B), e);
    push(K_KEY, 8'h00, e);
    push(K_NOTE, 4'h0, e + 1);
    tick_until(e + 5);

    // 5: switch mask gates eligibility
    switch_uri = 8'hF7;
    send(frame_of(8'h2B), e);
    push(K_KEY, 8'h08, e);
    tick_until(e + 10);
    direct("masked note_valid", int'(note_valid), 0);
    direct("masked tone_out", int'(tone_out), 0);
    switch_uri = 8'hFF;
    s = cyc;
    push(K_NOTE, 4'hB, s + 1);
    tick_until(s + 10);
    switch_uri = 8'hF7;
    s = cyc;
    push(K_NOTE, 4'h0, s + 1);
    tick_until(s + 5);
    send(frame_of(8'hF0), e);
    send(frame_of(8'h2B), e);
    push(K_KEY, 8'h00, e);
    tick_until(e + 5);
    switch_uri = 8'hFF;

    // 6: reset while tone high and after a pending F0
    send(frame_of(8'h1C), e);
    push(K_KEY, 8'h01, e);
    push(K_NOTE, 4'h8, e + 1);
    push(K_TONE, 1, e + 1 + H0);
    tick_until(e + 1 + H0 + 5);
    send(frame_of(8'hF0), e);
    @(posedge clk); #1;
    rst = 1'b1;
    s = cyc;
    push(K_KEY, 8'h00, s + 1);
    push(K_NOTE, 4'h0, s + 1);
    push(K_TONE, 0, s + 1);
    @(posedge clk); #1;
    rst = 1'b0;
    direct("rst key_state", int'(key_state), 0);
    direct("rst note", int'({note_valid, note_idx}), 0);
    direct("rst tone_out", int'(tone_out), 0);
    send(frame_of(8'h1C), e);
    push(K_KEY, 8'h01, e);
    push(K_NOTE, 4'h8, e + 1);
    tick_until(e + 5);
    send(frame_of(8'hF0), e);
    send(frame_of(8'h1C), e);
    push(K_KEY, 8'h00, e);
    push(K_NOTE, 4'h0, e + 1);
    tick_until(e + 10);

    direct("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
